// File: rtl/branch_hazard_controller.sv
// Decode-stage hazard sequencer: load/ALU-to-branch and load-use stalls,
// ID branch forwarding selects, taken-branch flush and a saturating stall counter.
module branch_hazard_controller #(
  parameter int          CNT_W    = 16,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_BNE   = 6'b000101,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_J     = 6'b000010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       operation,
  input  logic [4:0]       ifidRs,
  input  logic [4:0]       ifidRt,
  input  logic             idexRegWrite,
  input  logic             idexMemRead,
  input  logic [4:0]       idexWriteReg,
  input  logic             exmeRegWrite,
  input  logic             exmeMemtoReg,
  input  logic [4:0]       exmeWriteReg,
  input  logic             branchEqual,
  input  logic             hold,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexBubble,
  output logic             ifidFlush,
  output logic             fwdRs,
  output logic             fwdRt,
  output logic             busy,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic {RUN, STALL} stateT;

  logic [1:0] cnt;
  logic [1:0] cntNext;
  logic [1:0] need;
  stateT      state;
  logic       useRs, useRt, isBr, taken, stall;
  logic       idexMatch, exmeMatchRs, exmeMatchRt, exmeMatch;

  assign useRs = (operation != OP_J);
  assign useRt = (operation == OP_RTYPE) || (operation == OP_BEQ) ||
                 (operation == OP_BNE)   || (operation == OP_SW);
  assign isBr  = (operation == OP_BEQ) || (operation == OP_BNE);
  assign taken = (operation == OP_BEQ) ? branchEqual : !branchEqual;

  // Register 0 is hardwired, so it never produces a hazard or a forward.
  assign idexMatch   = (useRs && (idexWriteReg != 5'd0) && (ifidRs == idexWriteReg)) ||
                       (useRt && (idexWriteReg != 5'd0) && (ifidRt == idexWriteReg));
  assign exmeMatchRs = useRs && (exmeWriteReg != 5'd0) && (ifidRs == exmeWriteReg);
  assign exmeMatchRt = useRt && (exmeWriteReg != 5'd0) && (ifidRt == exmeWriteReg);
  assign exmeMatch   = exmeMatchRs || exmeMatchRt;

  always_comb begin
    need = 2'd0;
    if (isBr && idexMatch && idexRegWrite && idexMemRead)
      need = 2'd2;
    else if (isBr && idexMatch && idexRegWrite)
      need = 2'd1;
    else if (isBr && exmeMatch && exmeRegWrite && exmeMemtoReg)
      need = 2'd1;
    else if (!isBr && idexMatch && idexMemRead)
      need = 2'd1;
  end

  assign state = (cnt != 2'd0) ? STALL : RUN;
  assign stall = (state == STALL) || (need != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      stallCount <= '0;
    end else begin
      cnt <= cntNext;
      if (idexBubble && (stallCount != {CNT_W{1'b1}}))
        stallCount <= stallCount + CNT_W'(1);
    end
  end

  // Once in STALL the count runs down unconditionally; only RUN looks at need.
  always_comb begin
    cntNext = cnt;
    if (!hold) begin
      case (state)
        STALL:   cntNext = cnt - 2'd1;
        default: cntNext = (need != 2'd0) ? need - 2'd1 : 2'd0;
      endcase
    end
  end

  always_comb begin
    pcWrite    = 1'b0;
    ifidWrite  = 1'b0;
    idexBubble = 1'b1;
    ifidFlush  = 1'b0;
    fwdRs      = 1'b0;
    fwdRt      = 1'b0;
    busy       = 1'b0;
    if (rst_n) begin
      busy = (state == STALL);
      if (hold) begin
        idexBubble = 1'b0;
      end else begin
        pcWrite    = !stall;
        ifidWrite  = !stall;
        idexBubble = stall;
        ifidFlush  = isBr && !stall && taken;
        fwdRs      = isBr && exmeMatchRs && exmeRegWrite && !exmeMemtoReg;
        fwdRt      = isBr && exmeMatchRt && exmeRegWrite && !exmeMemtoReg;
      end
    end
  end

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed bench for branch_hazard_controller: a vector table for single-cycle
// decisions plus hand-written multi-cycle stall, hold, reset and saturation sequences.
module tb_branch_hazard_controller;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  operation;
  logic [4:0]  ifidRs, ifidRt;
  logic        idexRegWrite, idexMemRead;
  logic [4:0]  idexWriteReg;
  logic        exmeRegWrite, exmeMemtoReg;
  logic [4:0]  exmeWriteReg;
  logic        branchEqual, hold;
  logic        pcWrite, ifidWrite, idexBubble, ifidFlush, fwdRs, fwdRt, busy;
  logic [15:0] stallCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_hazard_controller dut (
    .clk(clk), .rst_n(rst_n), .operation(operation), .ifidRs(ifidRs), .ifidRt(ifidRt),
    .idexRegWrite(idexRegWrite), .idexMemRead(idexMemRead), .idexWriteReg(idexWriteReg),
    .exmeRegWrite(exmeRegWrite), .exmeMemtoReg(exmeMemtoReg), .exmeWriteReg(exmeWriteReg),
    .branchEqual(branchEqual), .hold(hold), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .idexBubble(idexBubble), .ifidFlush(ifidFlush), .fwdRs(fwdRs), .fwdRt(fwdRt),
    .busy(busy), .stallCount(stallCount)
  );

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       idRW, idMR;
    logic [4:0] idWR;
    logic       exRW, exM2R;
    logic [4:0] exWR;
    logic       brEq, hld;
    logic       expPc, expBub, expFlush, expFwdRs, expFwdRt, expBusy;
  } vecT;

  vecT vec [15];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic idRW, input logic idMR, input logic [4:0] idWR,
                               input logic exRW, input logic exM2R, input logic [4:0] exWR,
                               input logic brEq, input logic hld);
    operation = op;  ifidRs = rs;  ifidRt = rt;
    idexRegWrite = idRW;  idexMemRead = idMR;  idexWriteReg = idWR;
    exmeRegWrite = exRW;  exmeMemtoReg = exM2R;  exmeWriteReg = exWR;
    branchEqual = brEq;  hold = hld;
  endtask

  // Holds reset across one rising edge and releases it at the following falling edge.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(OP_J, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkEnables(input string name, input logic expPc, input logic expBub, input logic expBusy);
    checkOutput({name, ".pcWrite"}, 32'(pcWrite), 32'(expPc));
    checkOutput({name, ".ifidWrite"}, 32'(ifidWrite), 32'(expPc));
    checkOutput({name, ".idexBubble"}, 32'(idexBubble), 32'(expBub));
    checkOutput({name, ".busy"}, 32'(busy), 32'(expBusy));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(OP_J, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);

    vec[0]  = '{"brAluFwdRt",   OP_BEQ, 5'd12, 5'd9, 0,0,5'd0, 1,0,5'd9,  0,0, 1,0,0,0,1,0};
    vec[1]  = '{"rtypeNoFwd",   OP_R,   5'd12, 5'd9, 0,0,5'd0, 1,0,5'd9,  0,0, 1,0,0,0,0,0};
    vec[2]  = '{"bneAluFwdRs",  OP_BNE, 5'd9,  5'd3, 0,0,5'd0, 1,0,5'd9,  1,0, 1,0,0,1,0,0};
    vec[3]  = '{"bneTaken",     OP_BNE, 5'd1,  5'd2, 0,0,5'd0, 0,0,5'd0,  0,0, 1,0,1,0,0,0};
    vec[4]  = '{"beqNotTaken",  OP_BEQ, 5'd1,  5'd2, 0,0,5'd0, 0,0,5'd0,  0,0, 1,0,0,0,0,0};
    vec[5]  = '{"reg0Beq",      OP_BEQ, 5'd0,  5'd0, 1,1,5'd0, 1,0,5'd0,  1,0, 1,0,1,0,0,0};
    vec[6]  = '{"reg0Bne",      OP_BNE, 5'd0,  5'd0, 1,1,5'd0, 1,0,5'd0,  1,0, 1,0,0,0,0,0};
    vec[7]  = '{"brAluIdex",    OP_BEQ, 5'd7,  5'd8, 1,0,5'd8, 0,0,5'd0,  1,0, 0,1,0,0,0,0};
    vec[8]  = '{"brExmeLoad",   OP_BEQ, 5'd7,  5'd8, 0,0,5'd0, 1,1,5'd7,  1,0, 0,1,0,0,0,0};
    vec[9]  = '{"jNoSources",   OP_J,   5'd9,  5'd9, 1,1,5'd9, 0,0,5'd0,  0,0, 1,0,0,0,0,0};
    vec[10] = '{"iTypeRtFree",  OP_ADDI,5'd1,  5'd9, 1,1,5'd9, 0,0,5'd0,  0,0, 1,0,0,0,0,0};
    vec[11] = '{"swRtLoadUse",  OP_SW,  5'd1,  5'd9, 1,1,5'd9, 0,0,5'd0,  0,0, 0,1,0,0,0,0};
    vec[12] = '{"holdHazard",   OP_BEQ, 5'd12, 5'd9, 1,1,5'd9, 1,0,5'd12, 1,1, 0,0,0,0,0,0};
    vec[13] = '{"rtypeIdexAlu", OP_R,   5'd3,  5'd4, 1,0,5'd4, 0,0,5'd0,  0,0, 1,0,0,0,0,0};
    vec[14] = '{"brExmeNoWr",   OP_BEQ, 5'd5,  5'd6, 0,0,5'd0, 0,0,5'd5,  1,0, 1,0,1,0,0,0};

    // Reset state while rst_n is low.
    @(negedge clk);
    #2;
    checkEnables("reset", 1'b0, 1'b1, 1'b0);
    checkOutput("reset.ifidFlush", 32'(ifidFlush), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checkOutput("reset.stallCount", 32'(stallCount), 32'd0);

    for (int i = 0; i < 15; i++) begin
      doReset();
      applyStimulus(vec[i].op, vec[i].rs, vec[i].rt, vec[i].idRW, vec[i].idMR, vec[i].idWR,
                    vec[i].exRW, vec[i].exM2R, vec[i].exWR, vec[i].brEq, vec[i].hld);
      #2;
      checkEnables(vec[i].name, vec[i].expPc, vec[i].expBub, vec[i].expBusy);
      checkOutput({vec[i].name, ".ifidFlush"}, 32'(ifidFlush), 32'(vec[i].expFlush));
      checkOutput({vec[i].name, ".fwdRs"}, 32'(fwdRs), 32'(vec[i].expFwdRs));
      checkOutput({vec[i].name, ".fwdRt"}, 32'(fwdRt), 32'(vec[i].expFwdRt));
    end

    // Two-cycle load-to-branch stall with the pipeline advancing.
    doReset();
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 1, 1, 5'd9, 0, 0, 5'd0, 0, 0);
    #2;
    checkEnables("ldBr.c0", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 0, 0, 5'd0, 1, 1, 5'd9, 0, 0);
    #2;
    checkEnables("ldBr.c1", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    #2;
    checkEnables("ldBr.c2", 1'b1, 1'b0, 1'b0);
    checkOutput("ldBr.c2.fwdRt", 32'(fwdRt), 32'd0);
    checkOutput("ldBr.stallCount", 32'(stallCount), 32'd2);

    // Load-use on an R-type: exactly one bubble, never busy.
    doReset();
    applyStimulus(OP_R, 5'd4, 5'd5, 1, 1, 5'd5, 0, 0, 5'd0, 0, 0);
    #2;
    checkEnables("ldUse.c0", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(OP_R, 5'd4, 5'd5, 0, 0, 5'd0, 1, 1, 5'd5, 0, 0);
    #2;
    checkEnables("ldUse.c1", 1'b1, 1'b0, 1'b0);
    checkOutput("ldUse.stallCount", 32'(stallCount), 32'd1);

    // Hold during the busy cycle freezes the counter and the stall count.
    doReset();
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 1, 1, 5'd9, 0, 0, 5'd0, 0, 0);
    @(negedge clk);
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 0, 0, 5'd0, 1, 1, 5'd9, 1, 1);
    for (int c = 0; c < 3; c++) begin
      #2;
      checkEnables("hold.frozen", 1'b0, 1'b0, 1'b1);
      checkOutput("hold.ifidFlush", 32'(ifidFlush), 32'd0);
      checkOutput("hold.stallCount", 32'(stallCount), 32'd1);
      @(negedge clk);
    end
    hold = 1'b0;
    #2;
    checkEnables("hold.resume", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    #2;
    checkEnables("hold.done", 1'b1, 1'b0, 1'b0);
    checkOutput("hold.total", 32'(stallCount), 32'd2);

    // Reset arriving in the busy cycle.
    doReset();
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 1, 1, 5'd9, 0, 0, 5'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 0, 0, 5'd0, 1, 1, 5'd9, 0, 0);
    #2;
    checkEnables("midRst.low", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_BEQ, 5'd12, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    #2;
    checkEnables("midRst.run", 1'b1, 1'b0, 1'b0);
    checkOutput("midRst.stallCount", 32'(stallCount), 32'd0);

    // Sustained load-use hazard bubbles every cycle until the counter saturates.
    doReset();
    applyStimulus(OP_R, 5'd4, 5'd5, 1, 1, 5'd5, 0, 0, 5'd0, 0, 0);
    repeat (65534) @(negedge clk);
    #2;
    checkOutput("sat.below", 32'(stallCount), 32'hFFFE);
    @(negedge clk);
    #2;
    checkOutput("sat.reached", 32'(stallCount), 32'hFFFF);
    repeat (3) @(negedge clk);
    #2;
    checkOutput("sat.held", 32'(stallCount), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_hazard_controller.md
Name: branch_hazard_controller

Overview:
Decode-stage hazard and stall sequencer for the 5-stage MIPS pipeline. It decides when IF/ID and PC freeze and when a bubble enters ID/EX. It drives the decode-stage branch forwarding selects and flushes IF/ID on a taken beq/bne resolved in ID. A down-counter holds multi-cycle load-to-branch stalls, and a saturating counter accumulates stall cycles for performance measurement.

Parameters:
CNT_W, 16, width of stallCount
OP_RTYPE, 6'b000000, R-type opcode (uses rs, rt)
OP_BEQ, 6'b000100, beq opcode (uses rs, rt; taken when equal)
OP_BNE, 6'b000101, bne opcode (uses rs, rt; taken when not equal)
OP_SW, 6'b101011, sw opcode (uses rs, rt)
OP_J, 6'b000010, j opcode (uses no registers)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
operation  in  6  opcode of instruction in IF/ID
ifidRs  in  5  rs field of IF/ID instruction
ifidRt  in  5  rt field of IF/ID instruction
idexRegWrite  in  1  ID/EX instruction writes register file
idexMemRead  in  1  ID/EX instruction is a load
idexWriteReg  in  5  ID/EX destination register
exmeRegWrite  in  1  EX/MEM instruction writes register file
exmeMemtoReg  in  1  EX/MEM instruction is a load
exmeWriteReg  in  5  EX/MEM destination register
branchEqual  in  1  ID comparator result (operands equal, after forwarding)
hold  in  1  external freeze (memory wait); freezes whole pipeline
pcWrite  out  1  PC load enable
ifidWrite  out  1  IF/ID load enable
idexBubble  out  1  zero ID/EX control fields this cycle
ifidFlush  out  1  clear IF/ID (taken branch)
fwdRs  out  1  select EX/MEM ALU result for ID comparator operand rs
fwdRt  out  1  select EX/MEM ALU result for ID comparator operand rt
busy  out  1  high while in forced STALL state
stallCount  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Source usage: useRs = (operation != OP_J). useRt = operation in {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW}. isBr = operation in {OP_BEQ, OP_BNE}.
- match(X, R): usage flag of the operand is set, R != 0, and the operand's register field == R. Register 0 never creates a hazard or a forward.
- Required stall count n (combinational). The ID/EX check takes priority; n is the max of all applicable cases:
  - isBr, ID/EX match, idexRegWrite, idexMemRead: n = 2.
  - isBr, ID/EX match, idexRegWrite, no load: n = 1.
  - isBr, EX/MEM match, exmeRegWrite, exmeMemtoReg: n = 1.
  - not isBr, ID/EX match, idexMemRead: n = 1.
  - Otherwise n = 0.
- fwdRs and fwdRt are set when all hold: isBr, the operand matches exmeWriteReg, exmeRegWrite = 1, exmeMemtoReg = 0. They are 0 otherwise, and 0 when hold = 1.
- State: 2-bit cnt. STATE RUN when cnt == 0, STATE STALL when cnt != 0. busy = (cnt != 0).
  - stall = (cnt != 0) || (n != 0).
  - Outputs: pcWrite = ifidWrite = !stall; idexBubble = stall.
  - RUN, n != 0: cnt <= n-1. A 2-cycle load-to-branch stall therefore enters STALL for exactly one more cycle.
  - STALL: cnt <= cnt-1 regardless of n. Stall is forced and n is not re-evaluated.
  - Return to RUN: n is re-evaluated in the first RUN cycle. A new hazard restarts the sequence.
- Flush: ifidFlush = isBr && !stall && !hold && taken, with taken = branchEqual for beq and !branchEqual for bne. pcWrite stays 1 on flush. ifidFlush and idexBubble are never both 1.
- hold = 1 takes priority over everything:
  - pcWrite = ifidWrite = 0, idexBubble = 0, ifidFlush = 0.
  - cnt and stallCount are frozen.
- stallCount increments by 1 on each rising edge where idexBubble = 1. It saturates at all-ones and never wraps.
- Reset (rst_n low at a rising edge, including mid-stall): cnt <= 0 and stallCount <= 0. While rst_n is low, outputs are forced: pcWrite = 0, ifidWrite = 0, idexBubble = 1, ifidFlush = 0, fwdRs = fwdRt = 0, busy = 0. The first cycle after reset release is RUN.
- Latency: a hazard stalls in the same cycle it is visible (combinational). The counter affects the following cycles only.

Test Plan:
- beq r12,r9 with ID/EX load to r9 (idexRegWrite = 1, idexMemRead = 1): cycle0 stall = 1, busy = 0; cycle1 busy = 1, stall = 1; cycle2 RUN. With the pipeline model advancing, n = 0 and fwdRt = 0. stallCount = 2.
- beq r12,r9 with EX/MEM ALU write r9 (exmeRegWrite = 1, exmeMemtoReg = 0): no stall, fwdRt = 1, fwdRs = 0. Then operation = 000000: fwdRt = 0.
- Load-use: add r3,r4,r5 (R-type) with ID/EX load to r5: exactly 1 bubble, pcWrite = 0 for 1 cycle, busy stays 0.
- Register 0: beq r0,r0 with ID/EX load to r0 and EX/MEM write r0: n = 0, fwdRs = fwdRt = 0. branchEqual = 1 gives ifidFlush = 1; bne with branchEqual = 1 gives ifidFlush = 0.
- hold = 1 asserted during the busy cycle of a 2-cycle stall for 3 cycles: all enables 0, bubble 0, cnt and stallCount frozen. After release, the remaining stall cycle completes (total stallCount = 2).
- rst_n = 0 in the busy cycle: next cycle cnt = 0 and stallCount = 0. While rst_n is low: pcWrite = 0, idexBubble = 1. stallCount saturates at 16'hFFFF under a sustained forced hazard.
